// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared widths, state encoding and digit helper for the BCD-to-binary converter
package bcd_pkg;
   localparam int BCD_DIGITS = 3;
   localparam int BIN_W      = 10;
   localparam int SHREG_W    = 4 * BCD_DIGITS + BIN_W;
   localparam int ITER       = 10;
   localparam int CNT_W      = 4;
   localparam int BIN8_MAX   = 255;

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      DONE
   } state_e;

   function automatic logic is_bcd(input logic [3:0] d);
      return d <= 4'd9;
   endfunction
endpackage

// File: rtl/bcd_nibble_adj.sv
// rtl/bcd_nibble_adj.sv - reverse double-dabble correction: subtract 3 from a nibble that is 8 or more
module bcd_nibble_adj (
   input  logic [3:0] in_i,
   output logic [3:0] out_o
);
   assign out_o = (in_i >= 4'd8) ? (in_i - 4'd3) : in_i;
endmodule

// File: rtl/bcd_bin.sv
// rtl/bcd_bin.sv - three-digit BCD to 10-bit binary converter, one reverse double-dabble step per clock
module bcd_bin
   import bcd_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       hundreds,
   input  logic [3:0]       tens,
   input  logic [3:0]       ones,
   output logic [BIN_W-1:0] binary,
   output logic             gt255,
   output logic             err,
   output logic             busy,
   output logic             done
);
   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SHREG_W-1:0] sh_q, sh_d;
   logic [SHREG_W-1:0] sh_shift, sh_adj;
   logic [BIN_W-1:0]   bin_q, bin_d;
   logic               gt_q, gt_d;
   logic               err_q, err_d;
   logic               digits_ok;

   assign digits_ok = is_bcd(hundreds) && is_bcd(tens) && is_bcd(ones);

   // The BCD fields are corrected after the shift; the binary part passes straight through.
   assign sh_shift = sh_q >> 1;
   assign sh_adj[BIN_W-1:0] = sh_shift[BIN_W-1:0];

   for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
      bcd_nibble_adj u_adj (
         .in_i  (sh_shift[BIN_W + 4*g +: 4]),
         .out_o (sh_adj[BIN_W + 4*g +: 4])
      );
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      bin_d   = bin_q;
      gt_d    = gt_q;
      err_d   = err_q;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               sh_d  = {hundreds, tens, ones, {BIN_W{1'b0}}};
               cnt_d = '0;
               if (digits_ok) begin
                  state_d = CONV;
               end else begin
                  bin_d   = '0;
                  gt_d    = 1'b0;
                  err_d   = 1'b1;
                  state_d = DONE;
               end
            end
         end
         CONV: begin
            sh_d = sh_adj;
            if (cnt_q == LAST_ITER) begin
               cnt_d   = '0;
               bin_d   = sh_adj[BIN_W-1:0];
               gt_d    = sh_adj[BIN_W-1:0] > BIN_W'(BIN8_MAX);
               err_d   = 1'b0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sh_q    <= '0;
         bin_q   <= '0;
         gt_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         bin_q   <= bin_d;
         gt_q    <= gt_d;
         err_q   <= err_d;
      end
   end

   assign binary = bin_q;
   assign gt255  = gt_q;
   assign err    = err_q;
   assign busy   = (state_q == CONV);
   assign done   = (state_q == DONE);
endmodule
